// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath:
// FSM states, instruction classes, opcode/funct values and mux selects.
package mc_pkg;

    localparam int OPW = 6;
    localparam int STW = 4;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        C_R_ALU   = 4'd0,
        C_NOP     = 4'd1,
        C_JR      = 4'd2,
        C_I_ALU   = 4'd3,
        C_LOAD    = 4'd4,
        C_STORE   = 4'd5,
        C_BEQ     = 4'd6,
        C_J       = 4'd7,
        C_JAL     = 4'd8,
        C_ILLEGAL = 4'd9
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_J   = 2'd2;
    localparam logic [1:0] PC_SRC_RS  = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_BOFF = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class consumed by
// the control FSM. Anything not recognised classifies as illegal.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    output logic [3:0]     iclass
);

    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB: iclass = C_R_ALU;
                    FN_SLL:         iclass = C_NOP;
                    FN_JR:          iclass = C_JR;
                    default:        iclass = C_ILLEGAL;
                endcase
            end
            OP_ORI, OP_LUI: iclass = C_I_ALU;
            OP_LW:          iclass = C_LOAD;
            OP_SW:          iclass = C_STORE;
            OP_BEQ:         iclass = C_BEQ;
            OP_J:           iclass = C_J;
            OP_JAL:         iclass = C_JAL;
            default:        iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-memory MIPS datapath. One
// instruction at a time; stalls on mem_ready in FETCH and the memory states.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           iord,
    output logic           ir_we,
    output logic           pc_we,
    output logic [1:0]     pc_src,
    output logic           reg_we,
    output logic [1:0]     reg_dst,
    output logic [1:0]     wd_sel,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_op,
    output logic           ext_op,
    output logic           illegal,
    output logic [STW-1:0] state_o
);

    state_t     state;
    logic [3:0] iclass;

    mc_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass)
    );

    // IR only loads in FETCH, so the class is stable from DECODE onwards and
    // can steer ADDR without a separate lw/sw flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (iclass)
                        C_R_ALU:         state <= S_EXEC_R;
                        C_JR:            state <= S_JR;
                        C_I_ALU:         state <= S_EXEC_I;
                        C_LOAD, C_STORE: state <= S_ADDR;
                        C_BEQ:           state <= S_BRANCH;
                        C_J, C_JAL:      state <= S_JUMP;
                        default:         state <= S_FETCH;
                    endcase
                end
                S_EXEC_R: state <= S_WB_R;
                S_EXEC_I: state <= S_WB_I;
                S_ADDR:   state <= (iclass == C_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) state <= S_WB_MEM;
                S_MEM_WR: if (mem_ready) state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from state; reset forces them all low so an abandoned
    // store never strobes in the reset cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PC4;
        reg_we    = 1'b0;
        reg_dst   = REG_DST_RT;
        wd_sel    = WD_ALU;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_ADD;
        ext_op    = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_DECODE: illegal = (iclass == C_ILLEGAL);
                S_EXEC_R: begin
                    alu_src_b = SRCB_RT;
                    alu_op    = (funct == FN_SUB) ? ALU_SUB : ALU_ADD;
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = REG_DST_RD;
                end
                S_EXEC_I: begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
                end
                S_WB_I: reg_we = 1'b1;
                S_ADDR: begin
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = 1'b1;
                end
                S_WB_MEM: begin
                    reg_we = 1'b1;
                    wd_sel = WD_MDR;
                end
                S_BRANCH: begin
                    alu_op = ALU_SUB;
                    pc_src = PC_SRC_BR;
                    pc_we  = zero;
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_J;
                    if (opcode == OP_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = REG_DST_RA;
                        wd_sel  = WD_PC;
                    end
                end
                S_JR: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
                default: ;
            endcase
        end
    end

    assign state_o = reset ? STW'(S_FETCH) : STW'(state);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: builds each instruction's expected cycle-by-cycle output
// sequence from the instruction's class, then plays it with random waits/resets.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, ext_op, illegal;
    logic [1:0] pc_src, reg_dst, wd_sel, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst, wd_sel, alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op, illegal;
        logic [3:0] st;
    } outv_t;

    typedef struct {
        bit         rst, mr, z;
        logic [5:0] op, fn;
        outv_t      e;
        int         id;
    } cyc_t;

    localparam int K_R = 0, K_NOP = 1, K_JR = 2, K_I = 3, K_LW = 4, K_SW = 5,
                   K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

    cyc_t pq[$];
    int checks = 0, errors = 0;
    int n_regwe = 0, n_ill = 0, n_pcwe = 0, n_memwe = 0;

    function automatic int cls(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22) return K_R;
                if (fn == 6'h00) return K_NOP;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            6'h0d, 6'h0f: return K_I;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input bit rst, input bit mr, input bit z, input logic [5:0] op,
                        input logic [5:0] fn, input outv_t e, input int id);
        cyc_t c;
        c.rst = rst; c.mr = mr; c.z = z; c.op = op; c.fn = fn; c.e = e; c.id = id;
        pq.push_back(c);
    endtask

    task automatic push_rst(input int n, input int id);
        outv_t e;
        e = '0;
        e.st = S_FETCH;
        for (int i = 0; i < n; i++) push(1'b1, rbit(), rbit(), 6'($urandom), 6'($urandom), e, id);
    endtask

    // Expected sequence for one instruction: fw fetch stalls, mw memory stalls.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input bit z,
                        input int fw, input int mw, input int id);
        outv_t e;
        int k;
        k = cls(op, fn);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_req = 1; e.st = S_FETCH;
            push(0, 0, rbit(), 6'($urandom), 6'($urandom), e, id);
        end
        e = '0; e.mem_req = 1; e.ir_we = 1; e.pc_we = 1; e.st = S_FETCH;
        push(0, 1, rbit(), 6'($urandom), 6'($urandom), e, id);
        e = '0; e.st = S_DECODE; e.illegal = (k == K_ILL);
        push(0, rbit(), rbit(), op, fn, e, id);
        case (k)
            K_R: begin
                e = '0; e.st = S_EXEC_R; e.alu_op = (fn == 6'h22) ? 3'd1 : 3'd0;
                push(0, rbit(), rbit(), op, fn, e, id);
                e = '0; e.st = S_WB_R; e.reg_we = 1; e.reg_dst = 2'd1;
                push(0, rbit(), rbit(), op, fn, e, id);
            end
            K_I: begin
                e = '0; e.st = S_EXEC_I; e.alu_src_b = 2'd1; e.alu_op = (op == 6'h0f) ? 3'd3 : 3'd2;
                push(0, rbit(), rbit(), op, fn, e, id);
                e = '0; e.st = S_WB_I; e.reg_we = 1;
                push(0, rbit(), rbit(), op, fn, e, id);
            end
            K_LW, K_SW: begin
                e = '0; e.st = S_ADDR; e.alu_src_b = 2'd1; e.ext_op = 1;
                push(0, rbit(), rbit(), op, fn, e, id);
                e = '0; e.mem_req = 1; e.iord = 1;
                e.mem_we = (k == K_SW);
                e.st = (k == K_SW) ? S_MEM_WR : S_MEM_RD;
                for (int i = 0; i < mw; i++) push(0, 0, rbit(), op, fn, e, id);
                push(0, 1, rbit(), op, fn, e, id);
                if (k == K_LW) begin
                    e = '0; e.st = S_WB_MEM; e.reg_we = 1; e.wd_sel = 2'd1;
                    push(0, rbit(), rbit(), op, fn, e, id);
                end
            end
            K_BEQ: begin
                e = '0; e.st = S_BRANCH; e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = z;
                push(0, rbit(), z, op, fn, e, id);
            end
            K_J, K_JAL: begin
                e = '0; e.st = S_JUMP; e.pc_we = 1; e.pc_src = 2'd2;
                if (k == K_JAL) begin e.reg_we = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
                push(0, rbit(), rbit(), op, fn, e, id);
            end
            K_JR: begin
                e = '0; e.st = S_JR; e.pc_we = 1; e.pc_src = 2'd3;
                push(0, rbit(), rbit(), op, fn, e, id);
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, want);
        end
    endtask

    // Single compare point: inputs change just after posedge, outputs sampled at negedge.
    task automatic play();
        cyc_t  c;
        outv_t got;
        while (pq.size() > 0) begin
            c = pq.pop_front();
            @(posedge clk); #1;
            reset = c.rst; mem_ready = c.mr; zero = c.z; opcode = c.op; funct = c.fn;
            @(negedge clk);
            got = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                   wd_sel, alu_src_b, alu_op, ext_op, illegal, state_o};
            checks++;
            if (got !== c.e) begin
                errors++;
                $display("FAIL outputs instr%0d got %h exp %h", c.id, got, c.e);
            end
            n_regwe += int'(reg_we);
            n_ill   += int'(illegal);
            n_pcwe  += int'(pc_we);
            n_memwe += int'(mem_we);
        end
    endtask

    int n0, r0, i0, p0, m0;

    initial begin
        clk = 0; reset = 1; mem_ready = 0; zero = 0; opcode = '0; funct = '0;
        push_rst(2, 0);
        play();

        // Store abandoned by a 3-cycle reset while mem_ready is high.
        n0 = pq.size();
        plan(6'h2b, 6'h00, 0, 0, 2, 1);
        chk("len_sw_2wait", pq.size() - n0, 6);
        void'(pq.pop_back());
        push_rst(3, 1);
        for (int i = 0; i < 3; i++) pq[pq.size() - 1 - i].mr = 1;
        m0 = n_memwe;
        play();
        chk("memwe_before_reset", n_memwe - m0, 2);

        n0 = pq.size(); r0 = n_regwe;
        plan(6'h00, 6'h20, 0, 0, 0, 2);
        chk("len_add", pq.size() - n0, 4);
        play();
        chk("regwe_add", n_regwe - r0, 1);

        n0 = pq.size(); r0 = n_regwe;
        plan(6'h23, 6'h11, 0, 0, 2, 3);
        chk("len_lw_2wait", pq.size() - n0, 7);
        play();
        chk("regwe_lw", n_regwe - r0, 1);

        n0 = pq.size(); p0 = n_pcwe;
        plan(6'h04, 6'h00, 1, 0, 0, 4);
        chk("len_beq_taken", pq.size() - n0, 3);
        play();
        chk("pcwe_beq_taken", n_pcwe - p0, 2);
        n0 = pq.size(); p0 = n_pcwe;
        plan(6'h04, 6'h00, 0, 0, 0, 5);
        chk("len_beq_not", pq.size() - n0, 3);
        play();
        chk("pcwe_beq_not", n_pcwe - p0, 1);

        n0 = pq.size();
        plan(6'h03, 6'h00, 0, 0, 0, 6);
        chk("len_jal", pq.size() - n0, 3);
        n0 = pq.size(); r0 = n_regwe;
        plan(6'h00, 6'h08, 0, 0, 0, 7);
        chk("len_jr", pq.size() - n0, 3);
        play();
        chk("regwe_jal_jr", n_regwe - r0, 1);

        n0 = pq.size(); i0 = n_ill; p0 = n_pcwe; r0 = n_regwe; m0 = n_memwe;
        plan(6'h3f, 6'h00, 0, 0, 0, 8);
        chk("len_illegal", pq.size() - n0, 2);
        n0 = pq.size();
        plan(6'h00, 6'h00, 0, 0, 0, 9);
        chk("len_nop", pq.size() - n0, 2);
        play();
        chk("illegal_pulses", n_ill - i0, 1);
        chk("pcwe_fetch_only", n_pcwe - p0, 2);
        chk("regwe_none", n_regwe - r0, 0);
        chk("memwe_none", n_memwe - m0, 0);

        // Random instruction stream, random waits, occasional mid-instruction reset.
        for (int id = 100; id < 400; id++) begin
            logic [5:0] op, fn;
            int sel, len;
            sel = $urandom_range(0, 12);
            fn  = 6'($urandom);
            case (sel)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h00; end
                3: begin op = 6'h00; fn = 6'h08; end
                4: op = 6'h0d;
                5: op = 6'h0f;
                6: op = 6'h23;
                7: op = 6'h2b;
                8: op = 6'h04;
                9: op = 6'h02;
                10: op = 6'h03;
                default: op = 6'($urandom);
            endcase
            n0 = pq.size();
            plan(op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), id);
            len = pq.size() - n0;
            if ($urandom_range(0, 15) == 0) begin
                int cut;
                cut = $urandom_range(0, len - 1);
                for (int i = 0; i < cut; i++) void'(pq.pop_back());
                push_rst($urandom_range(1, 3), id);
            end
            play();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
